// File: rtl/axis_gauss_5x1.sv
`default_nettype none
// ============================================================================
// Module      : axis_gauss_5x1
// Description : Vertical 5-tap binomial (1 4 6 4 1)/16 filter on a raster
//               AXI-Stream, four line buffers, top-border row replication.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_gauss_5x1 #(
    parameter int DATA_WIDTH   = 8,
    parameter int COEFF_WIDTH  = 10,
    parameter int MAX_WIDTH    = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int FRAME_HEIGHT = 1080
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_arstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast
);

    localparam int SUM_W = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [SUM_W-1:0]      c_k0       = SUM_W'(2 ** (COEFF_WIDTH - 4));
    localparam logic [SUM_W-1:0]      c_k1       = SUM_W'(2 ** (COEFF_WIDTH - 2));
    localparam logic [SUM_W-1:0]      c_k2       = SUM_W'(3 * 2 ** (COEFF_WIDTH - 3));
    localparam logic [SUM_W:0]        c_round    = (SUM_W + 1)'(2 ** (COEFF_WIDTH - 1));
    localparam logic [SUM_W:0]        c_pix_max  = (SUM_W + 1)'(2 ** DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_col_max  = ADDR_WIDTH'(MAX_WIDTH - 1);
    localparam logic [ROW_W-1:0]      c_row_last = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [2:0]            c_line_sat = 3'd4;

    logic [ADDR_WIDTH-1:0] r_col;
    logic [2:0]            r_line;
    logic [ROW_W-1:0]      r_row;

    // Stage 1: beat registered alongside the synchronous line-buffer reads
    logic                  r_v1;
    logic                  r_last1;
    logic [DATA_WIDTH-1:0] r_pix1;
    logic [ADDR_WIDTH-1:0] r_col1;
    logic [2:0]            r_line1;
    logic [DATA_WIDTH-1:0] r_rd [4];
    logic [DATA_WIDTH-1:0] w_wr [4];

    logic [DATA_WIDTH-1:0] w_t1, w_t2, w_t3, w_t4;
    logic [SUM_W-1:0]      w_sum;

    logic                  r_v2;
    logic                  r_last2;
    logic [SUM_W-1:0]      r_sum;

    logic [SUM_W:0]        w_round;
    logic [SUM_W:0]        w_shift;
    logic [DATA_WIDTH-1:0] w_out;

    // Column / line / row counters; they only move on accepted beats
    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_col  <= '0;
            r_line <= '0;
            r_row  <= '0;
        end else if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
                r_col <= '0;
                if (r_row == c_row_last) begin
                    r_row  <= '0;
                    r_line <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                    if (r_line != c_line_sat) begin
                        r_line <= r_line + 1'b1;
                    end
                end
            end else if (r_col != c_col_max) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_pix1  <= '0;
            r_col1  <= '0;
            r_line1 <= '0;
        end else begin
            r_v1    <= s_axis_tvalid;
            r_last1 <= s_axis_tvalid & s_axis_tlast;
            r_pix1  <= s_axis_tdata;
            r_col1  <= r_col;
            r_line1 <= r_line;
        end
    end

    assign w_wr[0] = r_pix1;
    assign w_wr[1] = r_rd[0];
    assign w_wr[2] = r_rd[1];
    assign w_wr[3] = r_rd[2];

    // Each buffer shifts its column one line deeper when the beat writes back
    for (genvar g = 0; g < 4; g++) begin : g_lb
        logic [DATA_WIDTH-1:0] r_mem [MAX_WIDTH];

        always_ff @(posedge s_axis_aclk) begin
            r_rd[g] <= r_mem[r_col];
            if (r_v1) begin
                r_mem[r_col1] <= w_wr[g];
            end
        end
    end

    // Top border: taps above row 0 replicate the oldest valid row
    always_comb begin
        w_t1 = (r_line1 >= 3'd1) ? r_rd[0] : r_pix1;
        w_t2 = (r_line1 >= 3'd2) ? r_rd[1] : w_t1;
        w_t3 = (r_line1 >= 3'd3) ? r_rd[2] : w_t2;
        w_t4 = (r_line1 >= 3'd4) ? r_rd[3] : w_t3;
        w_sum = c_k0 * SUM_W'(r_pix1)
              + c_k1 * SUM_W'(w_t1)
              + c_k2 * SUM_W'(w_t2)
              + c_k1 * SUM_W'(w_t3)
              + c_k0 * SUM_W'(w_t4);
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_sum   <= '0;
        end else begin
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            r_sum   <= w_sum;
        end
    end

    always_comb begin
        w_round = {1'b0, r_sum} + c_round;
        w_shift = w_round >> COEFF_WIDTH;
        w_out   = (w_shift > c_pix_max) ? {DATA_WIDTH{1'b1}} : w_shift[DATA_WIDTH-1:0];
    end

    // Data holds its last value while the stream is idle
    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid <= r_v2;
            m_axis_tlast  <= r_last2;
            if (r_v2) begin
                m_axis_tdata <= w_out;
            end
        end
    end

endmodule
`default_nettype wire
